// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared definitions for the multicycle MIPS main controller.
//               Holds state encodings, opcode/funct constants, ALU codes,
//               mux-select encodings and the control-word structure.
// Revision    : 1.0 - initial release
//============================================================================
package mips_ctrl_pkg;

    // FSM state encodings (4-bit state register)
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    // ALU B operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // One cycle's worth of datapath control
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    // Idle control word: every strobe low, ALU left on ADD
    localparam ctrl_t CTRL_IDLE = '{
        pc_write:      1'b0,
        pc_write_cond: 1'b0,
        iord:          1'b0,
        mem_read:      1'b0,
        mem_write:     1'b0,
        ir_write:      1'b0,
        reg_dst:       1'b0,
        mem_to_reg:    1'b0,
        reg_write:     1'b0,
        alu_src_a:     1'b0,
        alu_src_b:     SRCB_B,
        pc_source:     PCSRC_ALU,
        alu_op:        ALU_ADD
    };

    // States that complete an instruction and hand control back to FETCH
    function automatic logic is_retire_state(input logic [3:0] st);
        return (st == S_MEMWB)  || (st == S_MEMWR)  || (st == S_ALUWB) ||
               (st == S_BRANCH) || (st == S_JUMP)   || (st == S_ADDIWB);
    endfunction

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
`default_nettype none
//============================================================================
// Module      : alu_decoder
// Description : Maps an R-type funct field to the 3-bit ALU opcode and
//               reports whether the funct is a supported operation.
//   funct       in  6  IR[5:0]
//   alu_op      out 3  ALU operation (ADD when funct unsupported)
//   funct_valid out 1  funct is add/sub/and/or
// Revision    : 1.0 - initial release
//============================================================================
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       funct_valid
);

    always_comb begin
        alu_op      = ALU_ADD;
        funct_valid = 1'b0;
        case (funct)
            FN_ADD: begin alu_op = ALU_ADD; funct_valid = 1'b1; end
            FN_SUB: begin alu_op = ALU_SUB; funct_valid = 1'b1; end
            FN_AND: begin alu_op = ALU_AND; funct_valid = 1'b1; end
            FN_OR:  begin alu_op = ALU_OR;  funct_valid = 1'b1; end
            default: begin
                alu_op      = ALU_ADD;
                funct_valid = 1'b0;
            end
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
//============================================================================
// Module      : mips_multicycle_ctrl
// Description : Main control FSM of the multicycle MIPS core. Sequences the
//               shared ALU, memory, IR, register file and PC through
//               FETCH/DECODE/EXECUTE/MEM/WB, counts retired instructions and
//               flags unsupported encodings.
//   clk, reset           clock / synchronous active-high reset
//   opcode, funct, zero  IR fields and ALU zero flag
//   pc_en .. alu_op      datapath control (Moore, pc_en also uses zero)
//   illegal_instr        one-cycle pulse in DECODE on a bad encoding
//   instr_count          retired-instruction counter (wraps)
//   state                current FSM state for debug
// Revision    : 1.0 - initial release
//============================================================================
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_en,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [2:0]       alu_op,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_retire;
    logic             w_illegal;
    logic [2:0]       w_funct_alu_op;
    logic             w_funct_valid;
    ctrl_t            w_ctrl;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .alu_op      (w_funct_alu_op),
        .funct_valid (w_funct_valid)
    );

    //------------------------------------------------------------------
    // Next-state, legality and retire decode
    //------------------------------------------------------------------
    always_comb begin
        w_next_state = S_FETCH;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE: begin
                        if (w_funct_valid) begin
                            w_next_state = S_EXEC;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    OP_BEQ:  w_next_state = S_BRANCH;
                    OP_J:    w_next_state = S_JUMP;
                    OP_ADDI: w_next_state = S_ADDIEX;
                    default: w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                // opcode is held by the IR, so only lw/sw can reach here
                if (opcode == OP_LW) begin
                    w_next_state = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    w_next_state = S_MEMWR;
                end
            end
            S_MEMRD:  w_next_state = S_MEMWB;
            S_EXEC:   w_next_state = S_ALUWB;
            S_ADDIEX: w_next_state = S_ADDIWB;
            default:  w_next_state = S_FETCH;
        endcase
    end

    assign w_retire = is_retire_state(r_state);

    //------------------------------------------------------------------
    // State and counter registers
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) begin
                r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    //------------------------------------------------------------------
    // Moore control word per state
    //------------------------------------------------------------------
    always_comb begin
        w_ctrl = CTRL_IDLE;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.ir_write  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Branch target PC + (imm << 2) is precomputed into ALUOut
                w_ctrl.alu_src_b = SRCB_IMM_SH;
            end
            S_MEMADR, S_ADDIEX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_op    = w_funct_alu_op;
            end
            S_ALUWB: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = SRCB_B;
                w_ctrl.alu_op        = ALU_SUB;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
                w_ctrl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                w_ctrl.pc_source = PCSRC_JUMP;
                w_ctrl.pc_write  = 1'b1;
            end
            S_ADDIWB: begin
                w_ctrl.reg_write = 1'b1;
            end
            default: w_ctrl = CTRL_IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // Outputs; reset suppresses every write strobe in the same cycle so an
    // interrupted instruction cannot touch architectural state.
    //------------------------------------------------------------------
    assign pc_write      = w_ctrl.pc_write      & ~reset;
    assign pc_write_cond = w_ctrl.pc_write_cond & ~reset;
    assign mem_read      = w_ctrl.mem_read      & ~reset;
    assign mem_write     = w_ctrl.mem_write     & ~reset;
    assign ir_write      = w_ctrl.ir_write      & ~reset;
    assign reg_write     = w_ctrl.reg_write     & ~reset;
    assign alu_op        = reset ? ALU_ADD : w_ctrl.alu_op;
    assign illegal_instr = w_illegal & ~reset;
    assign pc_en         = pc_write | (pc_write_cond & zero);

    assign iord       = w_ctrl.iord;
    assign reg_dst    = w_ctrl.reg_dst;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign pc_source  = w_ctrl.pc_source;

    assign instr_count = r_instr_count;
    assign state       = r_state;

endmodule : mips_multicycle_ctrl
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Directed self-checking bench for mips_multicycle_ctrl with a
//               4-bit retire counter so counter wrap is reachable.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             pc_en;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [2:0]       alu_op;
    logic             illegal_instr;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state;

    int n_checks = 0;
    int n_pass   = 0;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .pc_en         (pc_en),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .alu_op        (alu_op),
        .illegal_instr (illegal_instr),
        .instr_count   (instr_count),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // j from FETCH back to FETCH: 3 cycles
    task automatic run_jump();
        opcode = 6'h02;
        tick();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        opcode = 6'h23;
        funct  = 6'h00;
        zero   = 1'b0;

        // ---------------- reset held 3 cycles ----------------
        tick();
        check("rst_state",     32'(state),     32'd0);
        check("rst_mem_read",  32'(mem_read),  32'd0);
        check("rst_pc_write",  32'(pc_write),  32'd0);
        check("rst_ir_write",  32'(ir_write),  32'd0);
        check("rst_pc_en",     32'(pc_en),     32'd0);
        check("rst_alu_op",    32'(alu_op),    32'd2);
        check("rst_count",     32'(instr_count), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // ---------------- lw: 0,1,2,3,4,0 ----------------
        check("fetch_state",    32'(state),     32'd0);
        check("fetch_mem_read", 32'(mem_read),  32'd1);
        check("fetch_ir_write", 32'(ir_write),  32'd1);
        check("fetch_pc_en",    32'(pc_en),     32'd1);
        check("fetch_srcb",     32'(alu_src_b), 32'd1);
        check("fetch_iord",     32'(iord),      32'd0);
        tick();
        check("lw_s1",          32'(state),     32'd1);
        check("decode_srcb",    32'(alu_src_b), 32'd3);
        check("decode_regwr",   32'(reg_write), 32'd0);
        tick();
        check("lw_s2",          32'(state),     32'd2);
        check("memadr_srca",    32'(alu_src_a), 32'd1);
        check("memadr_srcb",    32'(alu_src_b), 32'd2);
        tick();
        check("lw_s3",          32'(state),     32'd3);
        check("memrd_mem_read", 32'(mem_read),  32'd1);
        check("memrd_iord",     32'(iord),      32'd1);
        check("memrd_regwr",    32'(reg_write), 32'd0);
        tick();
        check("lw_s4",          32'(state),     32'd4);
        check("memwb_regwr",    32'(reg_write), 32'd1);
        check("memwb_m2r",      32'(mem_to_reg), 32'd1);
        check("memwb_regdst",   32'(reg_dst),   32'd0);
        tick();
        check("lw_end_state",   32'(state),     32'd0);
        check("lw_end_regwr",   32'(reg_write), 32'd0);
        check("lw_count",       32'(instr_count), 32'd1);

        // ---------------- R-type sub ----------------
        opcode = 6'h00;
        funct  = 6'h22;
        tick();
        tick();
        check("sub_exec_state", 32'(state),     32'd6);
        check("sub_alu_op",     32'(alu_op),    32'd3);
        check("sub_srca",       32'(alu_src_a), 32'd1);
        check("sub_srcb",       32'(alu_src_b), 32'd0);
        tick();
        check("sub_wb_state",   32'(state),     32'd7);
        check("sub_regdst",     32'(reg_dst),   32'd1);
        check("sub_regwr",      32'(reg_write), 32'd1);
        check("sub_m2r",        32'(mem_to_reg), 32'd0);
        tick();
        check("sub_end_state",  32'(state),     32'd0);
        check("sub_count",      32'(instr_count), 32'd2);

        // R-type or in EXEC
        funct = 6'h25;
        tick();
        tick();
        check("or_alu_op",      32'(alu_op),    32'd1);
        tick();
        tick();
        check("or_count",       32'(instr_count), 32'd3);

        // ---------------- beq taken ----------------
        opcode = 6'h04;
        zero   = 1'b1;
        tick();
        check("beq_dec_pc_en",  32'(pc_en),     32'd0);
        tick();
        check("beq_t_state",    32'(state),     32'd8);
        check("beq_t_pc_en",    32'(pc_en),     32'd1);
        check("beq_t_pcsrc",    32'(pc_source), 32'd1);
        check("beq_t_alu_op",   32'(alu_op),    32'd3);
        tick();
        check("beq_t_end",      32'(state),     32'd0);
        check("beq_t_count",    32'(instr_count), 32'd4);

        // ---------------- beq not taken ----------------
        zero = 1'b0;
        tick();
        tick();
        check("beq_n_state",    32'(state),     32'd8);
        check("beq_n_pc_en",    32'(pc_en),     32'd0);
        check("beq_n_pwc",      32'(pc_write_cond), 32'd1);
        tick();
        check("beq_n_end",      32'(state),     32'd0);
        check("beq_n_count",    32'(instr_count), 32'd5);

        // ---------------- illegal opcode 0x3F ----------------
        opcode = 6'h3F;
        check("ill_fetch_pulse", 32'(illegal_instr), 32'd0);
        tick();
        check("ill_op_pulse",   32'(illegal_instr), 32'd1);
        tick();
        check("ill_op_state",   32'(state),     32'd0);
        check("ill_op_clear",   32'(illegal_instr), 32'd0);
        check("ill_op_count",   32'(instr_count), 32'd5);

        // ---------------- illegal funct 0x2A ----------------
        opcode = 6'h00;
        funct  = 6'h2A;
        tick();
        check("ill_fn_pulse",   32'(illegal_instr), 32'd1);
        tick();
        check("ill_fn_state",   32'(state),     32'd0);
        check("ill_fn_clear",   32'(illegal_instr), 32'd0);
        check("ill_fn_count",   32'(instr_count), 32'd5);

        // ---------------- j ----------------
        opcode = 6'h02;
        tick();
        tick();
        check("j_state",        32'(state),     32'd9);
        check("j_pcsrc",        32'(pc_source), 32'd2);
        check("j_pc_en",        32'(pc_en),     32'd1);
        tick();
        check("j_end",          32'(state),     32'd0);
        check("j_count",        32'(instr_count), 32'd6);

        // ---------------- addi ----------------
        opcode = 6'h08;
        tick();
        tick();
        check("addi_ex_state",  32'(state),     32'd10);
        check("addi_ex_srcb",   32'(alu_src_b), 32'd2);
        check("addi_ex_alu",    32'(alu_op),    32'd2);
        tick();
        check("addi_wb_state",  32'(state),     32'd11);
        check("addi_wb_regwr",  32'(reg_write), 32'd1);
        check("addi_wb_regdst", 32'(reg_dst),   32'd0);
        tick();
        check("addi_count",     32'(instr_count), 32'd7);

        // ---------------- sw aborted by reset in MEMWR ----------------
        opcode = 6'h2B;
        tick();
        tick();
        tick();
        check("sw_state",       32'(state),     32'd5);
        check("sw_mem_write",   32'(mem_write), 32'd1);
        reset = 1'b1;
        #1;
        check("sw_rst_mem_write", 32'(mem_write), 32'd0);
        tick();
        check("sw_rst_state",   32'(state),     32'd0);
        check("sw_rst_count",   32'(instr_count), 32'd0);
        check("sw_rst_mw2",     32'(mem_write), 32'd0);
        reset  = 1'b0;
        opcode = 6'h3F;
        #1;
        check("post_rst_fetch", 32'(mem_read),  32'd1);
        check("post_rst_mw_f",  32'(mem_write), 32'd0);
        tick();
        check("post_rst_mw_d",  32'(mem_write), 32'd0);
        tick();
        check("post_rst_state", 32'(state),     32'd0);
        check("post_rst_count", 32'(instr_count), 32'd0);

        // ---------------- counter wrap ----------------
        for (int i = 0; i < 15; i++) begin
            run_jump();
        end
        check("wrap_15",        32'(instr_count), 32'd15);
        run_jump();
        check("wrap_0",         32'(instr_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mips_multicycle_ctrl
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM of the multicycle MIPS core. Sequences the shared 32-bit ALU, memory, IR, register file and PC across FETCH/DECODE/EXECUTE/MEM/WB steps.
- Drives the 3-bit ALU opcode directly: AND=000, OR=001, ADD=010, SUB=011.
- Supports R-type add/sub/and/or, lw, sw, beq, j and addi.
- Counts retired instructions and flags illegal encodings.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; stable from the cycle after FETCH.
- funct  in  6  IR[5:0].
- zero  in  1  ALU result==0 flag, combinational from the ALU.
- pc_en  out  1  PC load enable = pc_write | (pc_write_cond & zero).
- pc_write  out  1  unconditional PC write.
- pc_write_cond  out  1  branch PC write qualifier.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_dst  out  1  register destination select: 0=rt, 1=rd.
- mem_to_reg  out  1  write-back data select: 0=ALUOut, 1=MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0=PC, 1=A register.
- alu_src_b  out  2  ALU B select: 00=B, 01=4, 10=signext imm, 11=signext imm<<2.
- pc_source  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target.
- alu_op  out  3  ALU operation code.
- illegal_instr  out  1  one-cycle pulse on an unsupported encoding.
- instr_count  out  CNT_W  retired-instruction count.
- state  out  4  current state, for debug.

Behaviour:
- Moore FSM with a 4-bit state register. Outputs are decoded from state only, except pc_en, which also uses zero. Unlisted outputs are 0 and alu_op defaults to ADD.
- FETCH(0):
  - mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00, pc_write=1.
  - Next state: DECODE.
- DECODE(1):
  - alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes the branch target).
  - Next state by opcode: 0x23/0x2B->MEMADR, 0x00 with valid funct->EXEC, 0x04->BRANCH, 0x02->JUMP, 0x08->ADDIEX.
  - Any other opcode or funct: next state FETCH, illegal_instr=1 for this cycle, count not incremented.
- MEMADR(2): alu_src_a=1, alu_src_b=10, ADD. Next: MEMRD if lw, MEMWR if sw.
- MEMRD(3): mem_read=1, iord=1. Next: MEMWB.
- MEMWB(4): reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH; retire.
- MEMWR(5): mem_write=1, iord=1. Next: FETCH; retire.
- EXEC(6): alu_src_a=1, alu_src_b=00, alu_op from funct (0x20->010, 0x22->011, 0x24->000, 0x25->001). Next: ALUWB.
- ALUWB(7): reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH; retire.
- BRANCH(8): alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_write_cond=1. Next: FETCH; retire whether or not the branch is taken.
- JUMP(9): pc_source=10, pc_write=1. Next: FETCH; retire.
- ADDIEX(10): alu_src_a=1, alu_src_b=10, ADD. Next: ADDIWB.
- ADDIWB(11): reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH; retire.
- Unused encodings 12-15: next state FETCH, all strobes 0, no retire.
- Cycle counts: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3, illegal=2.
- Retire: instr_count increments by 1 on the last-state->FETCH edge. Wraps modulo 2^CNT_W.
- Reset:
  - Synchronous, active-high. While reset=1, all strobes (pc_write, pc_write_cond, pc_en, mem_read, mem_write, ir_write, reg_write) are forced to 0, alu_op=ADD, illegal_instr=0.
  - Next state is FETCH and instr_count becomes 0.
  - Reset mid-instruction aborts it with no retire and no further writes. The first post-reset cycle is FETCH.
- zero is only consulted in BRANCH. A zero transition in any other state has no effect.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings;
  - opcode constants: RTYPE, LW, SW, BEQ, J, ADDI;
  - funct constants: ADD, SUB, AND, OR;
  - ALU codes: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=011;
  - alu_src_b and pc_source encodings.
- One sub-module, alu_decoder: funct -> {alu_op[2:0], funct_valid}, purely combinational. It is used in EXEC and by the DECODE legality check.

Test Plan:
- Reset held 3 cycles, then released with opcode=0x23 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_count=1.
- R-type funct=0x22 -> in EXEC, alu_op=011 and alu_src_a=1; in ALUWB, reg_dst=1; total 4 cycles; count increments.
- beq with zero=1 in BRANCH -> pc_en=1, pc_source=01. Repeated with zero=0 -> pc_en=0; both retire; 3 cycles each.
- opcode=0x3F, and separately opcode=0 with funct=0x2A -> illegal_instr pulses exactly once in DECODE, next state FETCH, instr_count unchanged.
- Reset asserted during MEMWR (sw) -> mem_write=0 in the reset cycle, state FETCH, count 0, no write strobe afterwards.
- Issue 2^CNT_W retires with CNT_W=4 -> counter wraps 15->0.
